// File: rtl/mc_stage_sequencer.sv
// Multi-cycle MIPS stage sequencer: fetch/decode/execute/memory/writeback enables with req/ack memory handshakes.
// Optional memory-ack timeout with a sticky ERROR state is built when SEQ_TIMEOUT_EN is defined.
module mc_stage_sequencer #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [1:0]       instr_class,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic             m_or_e,
    output logic             busy,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             timeout_err
);

`ifdef SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;
`endif

    localparam logic [1:0] CLS_ALU    = 2'b00;
    localparam logic [1:0] CLS_LOAD   = 2'b01;
    localparam logic [1:0] CLS_STORE  = 2'b10;
    localparam logic [1:0] CLS_BRANCH = 2'b11;

    if (MAX_WAIT == 0) begin : g_max_wait_check
        $error("mc_stage_sequencer: MAX_WAIT must be >= 1");
    end

    state_t     state;
    logic [1:0] cls;

    // Ack-qualified pulses are combinational so an ack completes its stage in the same cycle.
    assign imem_req     = (state == S_FETCH);
    assign dmem_req     = (state == S_MEM);
    assign fetch_en     = imem_req & imem_ack;
    assign decode_en    = (state == S_DECODE);
    assign execute_en   = (state == S_EXEC);
    assign memory_en    = dmem_req & dmem_ack;
    assign writeback_en = (state == S_WB);
    assign m_or_e       = writeback_en & (cls == CLS_LOAD);
    assign retire       = (execute_en & (instr_class == CLS_BRANCH))
                        | (memory_en & (cls == CLS_STORE))
                        | writeback_en;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;

    assign waiting     = (imem_req & ~imem_ack) | (dmem_req & ~dmem_ack);
    assign timeout_err = (state == S_ERROR);
    assign busy        = (state != S_IDLE) && (state != S_ERROR);
`else
    assign timeout_err = 1'b0;
    assign busy        = (state != S_IDLE);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cls        <= '0;
            retire_cnt <= '0;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) state <= S_DECODE;
`ifdef SEQ_TIMEOUT_EN
                    else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) state <= S_ERROR;
`endif
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    cls <= instr_class;
                    case (instr_class)
                        CLS_ALU:   state <= S_WB;
                        CLS_LOAD,
                        CLS_STORE: state <= S_MEM;
                        default:   state <= run ? S_FETCH : S_IDLE;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (cls == CLS_LOAD) state <= S_WB;
                        else                 state <= run ? S_FETCH : S_IDLE;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) state <= S_ERROR;
`endif
                end
                S_WB: state <= run ? S_FETCH : S_IDLE;
`ifdef SEQ_TIMEOUT_EN
                S_ERROR: state <= S_ERROR;
`endif
                default: state <= S_IDLE;
            endcase

            if (retire) retire_cnt <= retire_cnt + CNT_W'(1);

`ifdef SEQ_TIMEOUT_EN
            // Any cycle that is not an unanswered request leaves the counter at zero,
            // so it is already clear on every entry into FETCH or MEM.
            if (waiting) wait_cnt <= wait_cnt + WAIT_W'(1);
            else         wait_cnt <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_mc_stage_sequencer.sv
// Scoreboard bench for mc_stage_sequencer: per-instruction latency and pulse placement, counter, run/reset control.
module tb_mc_stage_sequencer;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned MAX_WAIT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic [1:0]       instr_class;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             dmem_req;
    logic             fetch_en;
    logic             decode_en;
    logic             execute_en;
    logic             memory_en;
    logic             writeback_en;
    logic             m_or_e;
    logic             busy;
    logic             retire;
    logic [CNT_W-1:0] retire_cnt;
    logic             timeout_err;

    mc_stage_sequencer #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .run(run), .instr_class(instr_class),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
        .memory_en(memory_en), .writeback_en(writeback_en), .m_or_e(m_or_e),
        .busy(busy), .retire(retire), .retire_cnt(retire_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cls;
        int         iw;
        int         dw;
    } exp_t;

    exp_t             sb[$];
    int               checks   = 0;
    int               failures = 0;

    bit               in_instr;
    int               cyc, f_at, d_at, e_at, m_at, w_at;
    logic             wb_src;
    logic [CNT_W-1:0] model_cnt;
    bit               cnt_pending, req_pending;
    logic             run_at_ret;

    task automatic clear_model();
        sb.delete();
        in_instr    = 0;
        cnt_pending = 0;
        req_pending = 0;
        model_cnt   = '0;
    endtask

    task automatic monitor_sample();
        int en_sum;
        exp_t e;
        int ef, ed, ee, em, ew, et;
        if (reset) begin
            in_instr = 0;
            return;
        end
        en_sum = int'(fetch_en) + int'(decode_en) + int'(execute_en) + int'(memory_en) + int'(writeback_en);
        checks++;
        if (en_sum > 1 || (imem_req && dmem_req) || (m_or_e && !writeback_en)) begin
            failures++;
            $display("FAIL protocol: enables=%0d imem_req=%b dmem_req=%b m_or_e=%b wb=%b (need <=1 enable, exclusive reqs, m_or_e only with wb)",
                     en_sum, imem_req, dmem_req, m_or_e, writeback_en);
        end
        if (cnt_pending) begin
            cnt_pending = 0;
            checks++;
            if (retire_cnt !== model_cnt) begin
                failures++;
                $display("FAIL retire_cnt: got %0d expected %0d", retire_cnt, model_cnt);
            end
        end
        if (req_pending) begin
            req_pending = 0;
            checks++;
            if (imem_req !== run_at_ret || busy !== run_at_ret) begin
                failures++;
                $display("FAIL after_retire: imem_req=%b busy=%b expected both %b", imem_req, busy, run_at_ret);
            end
        end
        if (!in_instr && imem_req) begin
            in_instr = 1;
            cyc = 0; f_at = -1; d_at = -1; e_at = -1; m_at = -1; w_at = -1; wb_src = 1'bx;
        end
        if (in_instr) begin
            cyc++;
            if (fetch_en     && f_at < 0) f_at = cyc;
            if (decode_en    && d_at < 0) d_at = cyc;
            if (execute_en   && e_at < 0) e_at = cyc;
            if (memory_en    && m_at < 0) m_at = cyc;
            if (writeback_en && w_at < 0) begin w_at = cyc; wb_src = m_or_e; end
            if (retire) begin
                in_instr = 0;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty: retire at cycle %0d with no expected instruction", cyc);
                end else begin
                    e  = sb.pop_front();
                    ef = 1 + e.iw;
                    ed = ef + 1;
                    ee = ed + 1;
                    em = (e.cls == 2'b01 || e.cls == 2'b10) ? ee + 1 + e.dw : -1;
                    ew = (e.cls == 2'b00) ? ee + 1 : (e.cls == 2'b01) ? em + 1 : -1;
                    et = (ew > 0) ? ew : (em > 0) ? em : ee;
                    if (cyc !== et) begin
                        failures++;
                        $display("FAIL latency cls=%0d: got %0d cycles expected %0d", e.cls, cyc, et);
                    end
                    checks++;
                    if (f_at !== ef || d_at !== ed || e_at !== ee || m_at !== em || w_at !== ew) begin
                        failures++;
                        $display("FAIL pulses cls=%0d: got F%0d D%0d E%0d M%0d W%0d expected F%0d D%0d E%0d M%0d W%0d",
                                 e.cls, f_at, d_at, e_at, m_at, w_at, ef, ed, ee, em, ew);
                    end
                    if (ew > 0) begin
                        checks++;
                        if (wb_src !== (e.cls == 2'b01)) begin
                            failures++;
                            $display("FAIL m_or_e cls=%0d: got %b expected %b", e.cls, wb_src, e.cls == 2'b01);
                        end
                    end
                end
                model_cnt   = model_cnt + 1'b1;
                cnt_pending = 1;
                req_pending = 1;
                run_at_ret  = run;
            end
        end else if (retire) begin
            checks++;
            failures++;
            $display("FAIL stray_retire: retire=1 outside an instruction");
        end
    endtask

    // Sample at the falling edge, then return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        monitor_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        clear_model();
    endtask

    task automatic wait_imem_req();
        int n = 0;
        while (!imem_req && n < 100) begin tick(); n++; end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL imem_req_timeout: imem_req=%b expected 1 within 100 cycles", imem_req);
        end
    endtask

    task automatic wait_dmem_req();
        int n = 0;
        while (!dmem_req && n < 100) begin tick(); n++; end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL dmem_req_timeout: dmem_req=%b expected 1 within 100 cycles", dmem_req);
        end
    endtask

    task automatic do_instr(input logic [1:0] cls, input int iw, input int dw, input bit drop_run);
        exp_t e;
        e.cls = cls; e.iw = iw; e.dw = dw;
        sb.push_back(e);
        wait_imem_req();
        repeat (iw) tick();
        imem_ack = 1'b1;
        tick();
        imem_ack    = 1'b0;
        instr_class = cls;
        if (drop_run) run = 1'b0;
        if (cls == 2'b01 || cls == 2'b10) begin
            wait_dmem_req();
            repeat (dw) tick();
            dmem_ack = 1'b1;
            tick();
            dmem_ack = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL drain: busy=%b pending=%0d expected idle and empty", busy, sb.size());
        end
        tick(); tick();
    endtask

    task automatic check_idle_outputs(input string name);
        logic [12:0] got;
        got = {imem_req, dmem_req, fetch_en, decode_en, execute_en, memory_en, writeback_en,
               m_or_e, busy, retire, timeout_err, 2'b00};
        checks++;
        if (got !== '0 || retire_cnt !== '0) begin
            failures++;
            $display("FAIL %s: outputs=%b retire_cnt=%0d expected all 0", name, got, retire_cnt);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_idle_outputs("reset_state");
        tick(); tick();
        check_idle_outputs("idle_no_run");
    endtask

    task automatic test_alu();
        apply_reset();
        run = 1'b1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL req_delay: imem_req=%b expected 0 in the cycle run rises", imem_req);
        end
        do_instr(2'b00, 0, 0, 1);
        drain();
    endtask

    task automatic test_load_waits();
        run = 1'b1;
        do_instr(2'b01, 2, 3, 1);
        drain();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run = 1'b1;
        do_instr(2'b10, 0, 0, 0);
        do_instr(2'b11, 0, 0, 1);
        drain();
        checks++;
        if (retire_cnt !== CNT_W'(2)) begin
            failures++;
            $display("FAIL b2b_count: retire_cnt=%0d expected 2", retire_cnt);
        end
        run = 1'b1;
        do_instr(2'b00, 1, 0, 0);
        do_instr(2'b01, 0, 2, 0);
        do_instr(2'b10, 3, 1, 0);
        do_instr(2'b11, 2, 0, 1);
        drain();
    endtask

    task automatic test_run_drop();
        run = 1'b1;
        do_instr(2'b01, 1, 1, 1);
        drain();
        repeat (3) tick();
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL run_drop_idle: imem_req=%b busy=%b expected 0 0", imem_req, busy);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        run = 1'b1;
        for (int i = 0; i < 16; i++) do_instr(2'b11, 0, 0, i == 15);
        drain();
        checks++;
        if (retire_cnt !== '0) begin
            failures++;
            $display("FAIL wrap: retire_cnt=%0d expected 0 after 16 retires", retire_cnt);
        end
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        run = 1'b1;
        do_instr(2'b11, 0, 0, 0);
        wait_imem_req();
        imem_ack = 1'b1;
        tick();
        imem_ack    = 1'b0;
        instr_class = 2'b10;
        wait_dmem_req();
        tick();
        reset = 1'b1;
        tick();
        check_idle_outputs("reset_mid_mem");
        reset = 1'b0;
        run   = 1'b0;
        clear_model();
        tick();
        check_idle_outputs("after_mid_reset");
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        run = 1'b1;
        wait_imem_req();
        imem_ack = 1'b1;
        tick();
        imem_ack    = 1'b0;
        instr_class = 2'b01;
        run         = 1'b0;
        wait_dmem_req();
        repeat (3) tick();
        checks++;
        if (dmem_req !== 1'b1 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL pre_timeout: dmem_req=%b timeout_err=%b expected 1 0", dmem_req, timeout_err);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (timeout_err !== 1'b1 || busy !== 1'b0 || dmem_req !== 1'b0 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL error_state: timeout_err=%b busy=%b dmem_req=%b imem_req=%b expected 1 0 0 0",
                         timeout_err, busy, dmem_req, imem_req);
            end
            run = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        check_idle_outputs("timeout_reset");
        reset = 1'b0;
        run   = 1'b0;
        clear_model();
    endtask
`endif

    initial begin
        reset = 1'b1; run = 1'b0; instr_class = 2'b00; imem_ack = 1'b0; dmem_ack = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_load_waits();
        test_back_to_back();
        test_run_drop();
        test_wrap();
        test_reset_mid_mem();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
